// File: rtl/can_rx_fifo.sv
// rtl/can_rx_fifo.sv - CAN receive FIFO: whole-frame byte store, per-frame length queue, overrun tracking
module can_rx_fifo #(
  parameter int DEPTH      = 64,
  parameter int INFO_DEPTH = 16,
  parameter int MAX_LEN    = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_mode,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       frame_done,
  input  logic       frame_abort,
  input  logic       release_buffer,
  input  logic       clear_data_overrun,
  input  logic [3:0] rd_offset,
  output logic [7:0] rd_data,
  output logic [3:0] rx_frame_len,
  output logic       rx_buffer_status,
  output logic [4:0] msg_count,
  output logic       data_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(INFO_DEPTH);

  logic [7:0]    mem  [DEPTH];
  logic [3:0]    info [INFO_DEPTH];
  logic [AW-1:0] wr_ptr, frame_start, rd_ptr;
  logic [AW:0]   byte_cnt;
  logic [3:0]    cur_len;
  logic          ovr_pending;
  logic [IW-1:0] info_wr, info_rd;

  logic          active, fifo_full, frame_full, wr_req, wr_ok, ovr_set, ovr_next;
  logic          commit, abort, discard, push, rel;
  logic [3:0]    pend_len, head_len, rel_len, disc_len;
  logic [AW:0]   byte_cnt_nxt;

  // The same-cycle write is folded into the pending frame before commit is judged.
  always_comb begin
    active     = !reset_mode;
    fifo_full  = (byte_cnt == (AW+1)'(DEPTH)) || (msg_count == 5'(INFO_DEPTH));
    frame_full = (cur_len == 4'(MAX_LEN));
    wr_req     = active && wr_en && !frame_abort;
    wr_ok      = wr_req && !fifo_full && !frame_full;
    ovr_set    = wr_req && fifo_full && !frame_full;
    pend_len   = cur_len + 4'(wr_ok);
    ovr_next   = ovr_pending || ovr_set;
    commit     = active && frame_done && !frame_abort;
    abort      = active && frame_abort;
    discard    = abort || (commit && ovr_next);
    push       = commit && !ovr_next && (pend_len != 4'd0);
    rel        = active && release_buffer && (msg_count != 5'd0);
    head_len   = info[info_rd];
    rel_len    = rel ? head_len : 4'd0;
    disc_len   = discard ? pend_len : 4'd0;
    byte_cnt_nxt = byte_cnt + (AW+1)'(wr_ok) - (AW+1)'(disc_len) - (AW+1)'(rel_len);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      frame_start <= '0;
      rd_ptr      <= '0;
      byte_cnt    <= '0;
      cur_len     <= '0;
      ovr_pending <= 1'b0;
      info_wr     <= '0;
      info_rd     <= '0;
      msg_count   <= '0;
    end else if (reset_mode) begin
      wr_ptr      <= '0;
      frame_start <= '0;
      rd_ptr      <= '0;
      byte_cnt    <= '0;
      cur_len     <= '0;
      ovr_pending <= 1'b0;
      info_wr     <= '0;
      info_rd     <= '0;
      msg_count   <= '0;
    end else begin
      wr_ptr      <= discard ? frame_start : wr_ptr + AW'(wr_ok);
      if (push)
        frame_start <= wr_ptr + AW'(wr_ok);
      byte_cnt    <= byte_cnt_nxt;
      cur_len     <= (commit || abort) ? 4'd0 : pend_len;
      ovr_pending <= (commit || abort) ? 1'b0 : ovr_next;
      if (push)
        info_wr <= info_wr + 1'b1;
      if (rel) begin
        info_rd <= info_rd + 1'b1;
        rd_ptr  <= rd_ptr + AW'(head_len);
      end
      msg_count   <= msg_count + 5'(push) - 5'(rel);
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      data_overrun <= 1'b0;
    else if (commit && ovr_next)
      data_overrun <= 1'b1;
    else if (clear_data_overrun)
      data_overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
    if (push)
      info[info_wr] <= pend_len;
  end

  always_comb begin
    rx_buffer_status = (msg_count != 5'd0);
    rx_frame_len     = rx_buffer_status ? info[info_rd] : 4'd0;
    rd_data          = (rx_buffer_status && (rd_offset < rx_frame_len))
                       ? mem[rd_ptr + AW'(rd_offset)] : 8'h00;
  end
endmodule

// File: tb/tb_can_rx_fifo.sv
// tb/tb_can_rx_fifo.sv - randomized bench for can_rx_fifo against a frame-level queue model
module tb_can_rx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       reset_mode = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       frame_done = 1'b0;
  logic       frame_abort = 1'b0;
  logic       release_buffer = 1'b0;
  logic       clear_data_overrun = 1'b0;
  logic [3:0] rd_offset = 4'd0;
  logic [7:0] rd_data;
  logic [3:0] rx_frame_len;
  logic       rx_buffer_status;
  logic [4:0] msg_count;
  logic       data_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: committed bytes, their frame lengths, the pending frame and the sticky flag.
  logic [7:0] data_q[$];
  int         len_q[$];
  logic [7:0] pend_q[$];
  bit         pend_ovr = 0;
  bit         m_dovr = 0;

  can_rx_fifo dut (
    .clk(clk), .rst(rst), .reset_mode(reset_mode), .wr_en(wr_en), .wr_data(wr_data),
    .frame_done(frame_done), .frame_abort(frame_abort), .release_buffer(release_buffer),
    .clear_data_overrun(clear_data_overrun), .rd_offset(rd_offset), .rd_data(rd_data),
    .rx_frame_len(rx_frame_len), .rx_buffer_status(rx_buffer_status),
    .msg_count(msg_count), .data_overrun(data_overrun)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    data_q.delete(); len_q.delete(); pend_q.delete();
    pend_ovr = 0; m_dovr = 0;
  endtask

  task automatic model_step(input bit we, input logic [7:0] wd, input bit fd, input bit fa,
                            input bit rel, input bit clr, input bit rm);
    bit set_ovr = 0;
    int total, nmsg, hl;
    if (rm) begin
      data_q.delete(); len_q.delete(); pend_q.delete(); pend_ovr = 0;
    end else begin
      total = data_q.size() + pend_q.size();
      nmsg  = len_q.size();
      if (fa) begin
        pend_q.delete(); pend_ovr = 0;
      end else begin
        if (we) begin
          if (pend_q.size() == 13) ;
          else if (total == 64 || nmsg == 16) pend_ovr = 1;
          else pend_q.push_back(wd);
        end
        if (fd) begin
          if (pend_ovr) set_ovr = 1;
          else if (pend_q.size() > 0) begin
            foreach (pend_q[i]) data_q.push_back(pend_q[i]);
            len_q.push_back(pend_q.size());
          end
          pend_q.delete(); pend_ovr = 0;
        end
      end
      if (rel && nmsg > 0) begin
        hl = len_q.pop_front();
        repeat (hl) void'(data_q.pop_front());
      end
    end
    if (set_ovr) m_dovr = 1;
    else if (clr) m_dovr = 0;
  endtask

  function automatic logic [7:0] exp_rd(input int off);
    if (len_q.size() > 0 && off < len_q[0]) return data_q[off];
    return 8'h00;
  endfunction

  // Compares status outputs and every read offset; all within one clock period.
  task automatic check_all(input string tag);
    check({tag, ".msg_count"}, 32'(msg_count), 32'(len_q.size()));
    check({tag, ".status"}, 32'(rx_buffer_status), 32'(len_q.size() != 0));
    check({tag, ".frame_len"}, 32'(rx_frame_len), 32'(len_q.size() ? len_q[0] : 0));
    check({tag, ".overrun"}, 32'(data_overrun), 32'(m_dovr));
    for (int o = 0; o < 16; o++) begin
      rd_offset = 4'(o);
      #1;
      check($sformatf("%s.rd[%0d]", tag, o), 32'(rd_data), 32'(exp_rd(o)));
    end
  endtask

  task automatic tick(input bit we, input logic [7:0] wd, input bit fd, input bit fa,
                      input bit rel, input bit clr);
    wr_en = we; wr_data = wd; frame_done = fd; frame_abort = fa;
    release_buffer = rel; clear_data_overrun = clr;
    @(posedge clk);
    model_step(we, wd, fd, fa, rel, clr, reset_mode);
    #1;
    wr_en = 0; frame_done = 0; frame_abort = 0; release_buffer = 0; clear_data_overrun = 0;
  endtask

  task automatic peek(input int off, input string tag, input logic [7:0] exp);
    rd_offset = 4'(off);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic send_frame(input int base, input int len);
    for (int i = 0; i < len; i++) tick(1, 8'(base + i), 0, 0, 0, 0);
    tick(0, 8'h00, 1, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] t1 [11];
    t1 = '{8'h08, 8'h11, 8'h22, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single 11-byte frame
    foreach (t1[i]) tick(1, t1[i], 0, 0, 0, 0);
    tick(0, 8'h00, 1, 0, 0, 0);
    check("t1.msg_count", 32'(msg_count), 32'd1);
    check("t1.frame_len", 32'(rx_frame_len), 32'd11);
    peek(2, "t1.rd2", 8'h22);
    peek(11, "t1.rd11", 8'h00);
    check_all("t1");
    tick(0, 8'h00, 0, 0, 1, 0);
    check_all("t1.rel");

    // Five 13-byte frames: the fifth overflows the byte store
    for (int f = 0; f < 5; f++) send_frame(f * 16, 13);
    check("t2.msg_count", 32'(msg_count), 32'd4);
    check("t2.overrun", 32'(data_overrun), 32'd1);
    check_all("t2");
    tick(0, 8'h00, 0, 0, 1, 0);
    peek(0, "t2.f2.rd0", 8'h10);
    peek(12, "t2.f2.rd12", 8'h1C);
    check_all("t2.rel");
    // Freed space: a further 13-byte frame now fits
    send_frame(8'h70, 13);
    check("t2.refill", 32'(msg_count), 32'd4);
    check_all("t2.refill");
    repeat (4) tick(0, 8'h00, 0, 0, 1, 0);
    tick(0, 8'h00, 0, 0, 0, 1);
    check_all("t2.drain");

    // Abort then a short frame
    for (int i = 0; i < 5; i++) tick(1, 8'hE0 + 8'(i), 0, 0, 0, 0);
    tick(0, 8'h00, 0, 1, 0, 0);
    send_frame(1, 3);
    check("t3.len", 32'(rx_frame_len), 32'd3);
    peek(0, "t3.rd0", 8'h01);
    check_all("t3");
    tick(0, 8'h00, 0, 0, 1, 0);

    // Wrap the byte store several times
    for (int k = 0; k < 12; k++) begin
      int len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) tick(1, 8'($urandom), 0, 0, 0, 0);
      tick(0, 8'h00, 1, 0, 0, 0);
      check_all("t4");
      tick(0, 8'h00, 0, 0, 1, 0);
    end
    check("t4.empty", 32'(msg_count), 32'd0);

    // Release together with commit
    send_frame(8'h30, 4);
    send_frame(8'h40, 5);
    tick(1, 8'h50, 0, 0, 0, 0);
    tick(1, 8'h51, 1, 0, 1, 0);
    check("t5.msg_count", 32'(msg_count), 32'd2);
    peek(0, "t5.head", 8'h40);
    check_all("t5");
    repeat (2) tick(0, 8'h00, 0, 0, 1, 0);
    tick(0, 8'h00, 0, 0, 1, 0);
    check("t5.empty_rel", 32'(msg_count), 32'd0);
    check_all("t5.empty");

    // Reset mode mid-frame with frames queued and overrun set
    for (int f = 0; f < 5; f++) send_frame(f * 16, 13);
    repeat (2) tick(0, 8'h00, 0, 0, 1, 0);
    check("t6.pre", 32'(msg_count), 32'd2);
    for (int i = 0; i < 3; i++) tick(1, 8'h99, 0, 0, 0, 0);
    reset_mode = 1'b1;
    tick(1, 8'h98, 1, 0, 1, 0);
    reset_mode = 1'b0;
    check("t6.msg_count", 32'(msg_count), 32'd0);
    check("t6.status", 32'(rx_buffer_status), 32'd0);
    check("t6.overrun", 32'(data_overrun), 32'd1);
    check_all("t6");
    rst = 1'b0;
    #1;
    model_reset();
    check("t6.rst_ovr", 32'(data_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      reset_mode = ($urandom_range(0, 199) == 0);
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
      reset_mode = 1'b0;
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
